// File: rtl/serial_arith_pkg.sv
// Shared types and limits for the bit-serial arithmetic blocks.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_MAX = 64;

   // Counter width for a block processing `width` bits, never below one bit.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder used as the serial adder's datapath cell.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell and a carry flop process one
// bit per clock, with valid/ready handshakes on operands and result.
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_next;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cout_r;
   logic             ovf_r;
   logic             cell_s;
   logic             cell_co;
   logic             last;

   full_adder_cell u_cell (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (cell_s),
      .co (cell_co)
   );

   assign last = (cnt == LAST);

   // New sum bits enter from the MSB so the LSB-first result ends up aligned.
   always_comb begin
      sum_next = sum_sh >> 1;
      sum_next[WIDTH-1] = cell_s;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid) next_state = RUN;
         RUN:     if (last)     next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  sum_sh <= '0;
                  cnt    <= '0;
                  carry  <= cin;
                  cout_r <= 1'b0;
                  ovf_r  <= 1'b0;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= sum_next;
               carry  <= cell_co;
               if (last) begin
                  // carry still holds the carry into the MSB on this cycle
                  cout_r <= cell_co;
                  ovf_r  <= carry ^ cell_co;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state == RUN);
      out_valid = (state == DONE);
      sum       = sum_sh;
      cout      = cout_r;
      ovf       = ovf_r;
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       in_ready8, out_valid8, cout8, ovf8, busy8;
   logic [7:0] sum8;

   logic       in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       in_ready1, out_valid1, cout1, ovf1, busy1;
   logic [0:0] sum1;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   // Model: per lane, edges remaining in the computation and the pending result.
   int          left [2];
   bit          done [2];
   logic [63:0] msum [2];
   bit          mcout[2];
   bit          movf [2];

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
   endtask

   task automatic model_step(input int l, input int w, input bit rs, input bit v, input bit r,
                             input logic [63:0] av, input logic [63:0] bv, input bit c);
      logic [64:0] full;
      logic [63:0] mask;
      if (rs) begin
         left[l] = 0; done[l] = 0; msum[l] = '0; mcout[l] = 0; movf[l] = 0;
      end else if (done[l]) begin
         if (r) done[l] = 0;
      end else if (left[l] > 0) begin
         left[l]--;
         if (left[l] == 0) done[l] = 1;
      end else if (v) begin
         mask     = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
         full     = {1'b0, av & mask} + {1'b0, bv & mask} + {64'd0, c};
         msum[l]  = full[63:0] & mask;
         mcout[l] = full[w];
         movf[l]  = (av[w-1] == bv[w-1]) && (msum[l][w-1] != av[w-1]);
         left[l]  = w;
      end
   endtask

   task automatic check_lane(input int l, input string nm, input bit ir, input bit bz, input bit ov,
                             input logic [63:0] s, input bit co, input bit of);
      check_output({nm, " in_ready"}, {63'd0, ir}, {63'd0, (!done[l] && left[l] == 0)});
      check_output({nm, " busy"}, {63'd0, bz}, {63'd0, (left[l] > 0)});
      check_output({nm, " out_valid"}, {63'd0, ov}, {63'd0, done[l]});
      if (done[l]) begin
         check_output({nm, " sum"}, s, msum[l]);
         check_output({nm, " cout"}, {63'd0, co}, {63'd0, mcout[l]});
         check_output({nm, " ovf"}, {63'd0, of}, {63'd0, movf[l]});
      end
   endtask

   // Inputs are only changed 1 time unit after an edge, so reading them at the edge is stable.
   always @(posedge clk) begin
      cyc++;
      model_step(0, 8, rst, in_valid8, out_ready8, {56'd0, a8}, {56'd0, b8}, cin8);
      model_step(1, 1, rst, in_valid1, out_ready1, {63'd0, a1}, {63'd0, b1}, cin1);
      #1;
      check_lane(0, "w8", in_ready8, busy8, out_valid8, {56'd0, sum8}, cout8, ovf8);
      check_lane(1, "w1", in_ready1, busy1, out_valid1, {63'd0, sum1}, cout1, ovf1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out8(output int edges);
      edges = 0;
      while (!out_valid8 && edges < 64) begin
         tick();
         edges++;
      end
   endtask

   // Present operands for one accepting edge, then count edges until out_valid.
   task automatic apply_stimulus8(input logic [7:0] av, input logic [7:0] bv, input bit c,
                                  output int edges);
      int e;
      a8 = av; b8 = bv; cin8 = c; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      wait_out8(e);
      edges = e + 1;
   endtask

   task automatic consume8();
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
   endtask

   task automatic run_op8(input string nm, input logic [7:0] av, input logic [7:0] bv, input bit c,
                          input logic [7:0] es, input bit ec, input bit eo);
      int edges;
      apply_stimulus8(av, bv, c, edges);
      check_output({nm, " latency"}, edges, 9);
      check_output({nm, " sum lit"}, {56'd0, sum8}, {56'd0, es});
      check_output({nm, " cout lit"}, {63'd0, cout8}, {63'd0, ec});
      check_output({nm, " ovf lit"}, {63'd0, ovf8}, {63'd0, eo});
      consume8();
      check_output({nm, " released"}, {62'd0, in_ready8, out_valid8}, 64'd2);
   endtask

   initial begin
      int edges;
      int pulses[$];
      bit prev;
      int ones;

      tick(); tick();
      check_output("reset sum", {56'd0, sum8}, 64'd0);
      check_output("reset flags", {59'd0, cout8, ovf8, out_valid8, busy8, in_ready8}, 64'd1);
      rst = 1'b0;
      tick();

      run_op8("5A+3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      run_op8("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op8("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      run_op8("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

      // Backpressure in DONE while new operands are offered
      apply_stimulus8(8'h5A, 8'h3C, 1'b0, edges);
      for (int i = 0; i < 5; i++) begin
         in_valid8 = i[0];
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         tick();
         check_output("hold sum", {56'd0, sum8}, 64'h96);
         check_output("hold ready", {62'd0, in_ready8, out_valid8}, 64'd1);
      end
      in_valid8 = 1'b0;
      consume8();
      check_output("bp release", {62'd0, in_ready8, out_valid8}, 64'd2);

      // out_ready and in_valid together in DONE: consumed, operands not bypassed
      apply_stimulus8(8'h10, 8'h20, 1'b0, edges);
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      check_output("no bypass", {61'd0, busy8, in_ready8, out_valid8}, 64'd2);
      tick();
      in_valid8 = 1'b0;
      check_output("accept after idle", {63'd0, busy8}, 64'd1);
      wait_out8(edges);
      check_output("no bypass sum", {56'd0, sum8}, 64'h02);
      consume8();

      // Reset after three RUN edges discards the operation
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_output("mid-run reset", {61'd0, busy8, in_ready8, out_valid8}, 64'd2);
      ones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid8) ones++;
      end
      check_output("no stale result", ones, 0);
      run_op8("12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

      // WIDTH=1: exhaustive registered full adder
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         a1 = v[2]; b1 = v[1]; cin1 = v[0]; in_valid1 = 1'b1;
         tick();
         in_valid1 = 1'b0;
         edges = 1;
         while (!out_valid1 && edges < 16) begin
            tick();
            edges++;
         end
         check_output("w1 latency", edges, 2);
         check_output("w1 {cout,sum}", {62'd0, cout1, sum1[0]},
                      64'(v[2]) + 64'(v[1]) + 64'(v[0]));
         out_ready1 = 1'b1;
         tick();
         out_ready1 = 1'b0;
      end

      // Back-to-back with in_valid and out_ready held high
      out_ready8 = 1'b1; in_valid8 = 1'b1;
      prev = 1'b0;
      for (int i = 0; i < 36; i++) begin
         if (i == 25) in_valid8 = 1'b0;
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         tick();
         if (out_valid8 && !prev) pulses.push_back(cyc);
         prev = out_valid8;
      end
      out_ready8 = 1'b0;
      check_output("b2b pulses", pulses.size(), 3);
      if (pulses.size() >= 3) begin
         check_output("b2b spacing 1", pulses[1] - pulses[0], 10);
         check_output("b2b spacing 2", pulses[2] - pulses[1], 10);
      end

      // Random traffic on both lanes, with occasional resets
      for (int i = 0; i < 400; i++) begin
         in_valid8  = 1'($urandom); out_ready8 = 1'($urandom);
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         in_valid1  = 1'($urandom); out_ready1 = 1'($urandom);
         a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0; in_valid8 = 1'b0; in_valid1 = 1'b0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d, expected finish", cyc);
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, LSB-first, with a valid/ready handshake on both input and output. It is the addition counterpart to the combinational full subtractor.
- One registered full-adder cell plus a carry flip-flop process one bit per clock, trading latency for area.
- Sits between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH
- cout  output  1  carry out of MSB
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  output  1  high in RUN

Behaviour:
- Clock and reset: single clock domain, clk; rst is synchronous and active-high, sampled on the rising edge of clk.
- States:
  - IDLE: in_ready=1.
  - RUN: busy=1.
  - DONE: out_valid=1.
- Reset: on any rising edge with rst=1 →
  - state=IDLE, bit counter=0, carry=0
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0
  - in_ready=1 from the next cycle
- Reset overrides all other inputs. Reset mid-RUN or mid-DONE discards the operation; no out_valid is produced.
- IDLE → RUN on in_valid && in_ready:
  - latch a into shift register A_sh and b into B_sh
  - carry ← cin, cnt ← 0
  - clear the sum shift register
- RUN, each cycle:
  - cell inputs: A_sh[0], B_sh[0], carry
  - shift s into the sum register from the MSB side (right-shift)
  - shift A_sh and B_sh right by 1
  - carry ← co; cnt ← cnt+1
  - when cnt==WIDTH-1: record carry-in-to-MSB (the carry value before this cycle's update) for ovf, then go to DONE
- RUN lasts exactly WIDTH cycles.
- Latency: out_valid rises WIDTH+1 clock edges after the accepting edge.
- DONE:
  - sum, cout, ovf held stable while out_ready=0 (arbitrary backpressure)
  - on out_ready=1 → IDLE, out_valid drops the next cycle
- Input acceptance:
  - in_valid is ignored outside IDLE; operand inputs are don't-care then
  - a, b, cin changing during RUN has no effect
- Throughput: with in_valid held high and out_ready=1, one result every WIDTH+2 cycles.
- Widths and wrap:
  - the counter is max(1,$clog2(WIDTH)) bits and never wraps past WIDTH-1
  - WIDTH=1 gives a single-cycle RUN, equivalent to a registered full adder
- Simultaneous events:
  - out_ready and in_valid both high in DONE → the result is consumed; the new operands are not accepted until IDLE (no bypass)
  - in_valid=0 in IDLE → stay in IDLE

Decomposition:
- Shared package serial_arith_pkg:
  - state enum {IDLE, RUN, DONE} as a 2-bit typedef
  - WIDTH_MAX=64 constant
- One sub-module, full_adder_cell (combinational):
  - inputs a, b, ci; outputs s = a^b^ci and co = majority(a,b,ci)
  - instantiated once in serial_adder

Test Plan:
- Reset, then WIDTH=8, a=0x5A, b=0x3C, cin=0 → after 9 edges out_valid=1, sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, ovf=1. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands → sum/cout/ovf unchanged, in_ready=0 throughout, new operands not taken; out_ready=1 → IDLE next cycle.
- Reset mid-RUN: assert rst for one cycle at cnt=3 → next cycle state IDLE, in_ready=1, out_valid never rises. A following operation 0x12+0x34 → sum=0x46.
- WIDTH=1 build, all 8 combinations of a, b, cin → {cout,sum} equals a+b+cin (e.g. 1,1,1 → sum=1, cout=1); out_valid 2 edges after acceptance.
- Back-to-back: in_valid and out_ready held high for 3 operations → out_valid pulses one cycle each, spaced exactly 10 cycles apart (WIDTH+2), results match a reference model.
